// File: rtl/co_sim_stream_checker.sv
// Aligns a golden stream to a DUT stream, compares them under a mask, counts
// matches/mismatches, captures the first mismatch and gives a registered verdict.
module co_sim_stream_checker #(
    parameter int DATA_W    = 128,
    parameter int ALIGN_DLY = 1,
    parameter int SETTLE    = 5,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] golden_data,
    input  logic [DATA_W-1:0] dut_data,
    input  logic [DATA_W-1:0] cmp_mask,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              mm_pulse,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [DATA_W-1:0] first_mm_golden,
    output logic [DATA_W-1:0] first_mm_dut,
    output logic [CNT_W-1:0]  first_mm_cycle
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [3:0]       DRAIN_LAST  = 4'(ALIGN_DLY);

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              launch_s;
    logic [7:0]        settle_cnt_r;
    logic [3:0]        drain_cnt_r;
    logic [CNT_W-1:0]  stamp_r;
    logic              in_run_s;
    logic              in_cmp_s;
    logic              inj_s;
    logic [DATA_W-1:0] g_al_s;
    logic [DATA_W-1:0] m_al_s;
    logic              s_al_s;
    logic [CNT_W-1:0]  t_al_s;
    logic              hit_s;
    logic              mm_s;

    assign in_run_s = (state_r == ST_RUN);
    assign in_cmp_s = in_run_s | (state_r == ST_DRAIN);
    assign inj_s    = sample_en & in_run_s;
    assign hit_s    = s_al_s & in_cmp_s;
    assign mm_s     = |((g_al_s ^ dut_data) & m_al_s);

    // Next-state decode; start wins over stop in IDLE/DONE
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_nxt_s = ST_DRAIN;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // The stamp travels with the sample so first_mm_cycle names the cycle the golden value was taken
    generate
        if (ALIGN_DLY == 0) begin : g_direct
            assign g_al_s = golden_data;
            assign m_al_s = cmp_mask;
            assign s_al_s = inj_s;
            assign t_al_s = stamp_r;
        end else begin : g_pipe
            logic [DATA_W-1:0] g_pipe_r [ALIGN_DLY];
            logic [DATA_W-1:0] m_pipe_r [ALIGN_DLY];
            logic [CNT_W-1:0]  t_pipe_r [ALIGN_DLY];
            logic              s_pipe_r [ALIGN_DLY];

            // Alignment shift register, flushed by reset and by a new run
            always_ff @(posedge clk) begin
                if (rst || launch_s) begin
                    for (int i = 0; i < ALIGN_DLY; i++) begin
                        g_pipe_r[i] <= '0;
                        m_pipe_r[i] <= '0;
                        t_pipe_r[i] <= '0;
                        s_pipe_r[i] <= 1'b0;
                    end
                end else begin
                    g_pipe_r[0] <= golden_data;
                    m_pipe_r[0] <= cmp_mask;
                    t_pipe_r[0] <= stamp_r;
                    s_pipe_r[0] <= inj_s;
                    for (int i = 1; i < ALIGN_DLY; i++) begin
                        g_pipe_r[i] <= g_pipe_r[i-1];
                        m_pipe_r[i] <= m_pipe_r[i-1];
                        t_pipe_r[i] <= t_pipe_r[i-1];
                        s_pipe_r[i] <= s_pipe_r[i-1];
                    end
                end
            end

            assign g_al_s = g_pipe_r[ALIGN_DLY-1];
            assign m_al_s = m_pipe_r[ALIGN_DLY-1];
            assign t_al_s = t_pipe_r[ALIGN_DLY-1];
            assign s_al_s = s_pipe_r[ALIGN_DLY-1];
        end
    endgenerate

    // State, phase counters, compare results and verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            settle_cnt_r    <= 8'd0;
            drain_cnt_r     <= 4'd0;
            stamp_r         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            fail            <= 1'b0;
            mm_pulse        <= 1'b0;
            match_cnt       <= '0;
            mismatch_cnt    <= '0;
            first_mm_golden <= '0;
            first_mm_dut    <= '0;
            first_mm_cycle  <= '0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_RUN) ||
                       (state_nxt_s == ST_DRAIN);
            done    <= (state_nxt_s == ST_DONE);

            if (state_r == ST_SETTLE) begin
                settle_cnt_r <= settle_cnt_r + 8'd1;
            end else begin
                settle_cnt_r <= 8'd0;
            end
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + 4'd1;
            end else begin
                drain_cnt_r <= 4'd0;
            end

            if (launch_s) begin
                stamp_r         <= '0;
                pass            <= 1'b0;
                fail            <= 1'b0;
                mm_pulse        <= 1'b0;
                match_cnt       <= '0;
                mismatch_cnt    <= '0;
                first_mm_golden <= '0;
                first_mm_dut    <= '0;
                first_mm_cycle  <= '0;
            end else begin
                mm_pulse <= hit_s & mm_s;
                if (hit_s && mm_s) begin
                    if (mismatch_cnt == '0) begin
                        first_mm_golden <= g_al_s;
                        first_mm_dut    <= dut_data;
                        first_mm_cycle  <= t_al_s;
                    end
                    if (mismatch_cnt != CNT_MAX) begin
                        mismatch_cnt <= mismatch_cnt + CNT_ONE;
                    end
                end
                if (hit_s && !mm_s && (match_cnt != CNT_MAX)) begin
                    match_cnt <= match_cnt + CNT_ONE;
                end
                if (in_cmp_s && (stamp_r != CNT_MAX)) begin
                    stamp_r <= stamp_r + CNT_ONE;
                end
                if ((state_r == ST_DRAIN) && (state_nxt_s == ST_DONE)) begin
                    pass <= (mismatch_cnt == '0) && (match_cnt != '0);
                    fail <= !((mismatch_cnt == '0) && (match_cnt != '0));
                end
            end
        end
    end

endmodule

// File: doc/co_sim_stream_checker.md
Name: co_sim_stream_checker

Overview:
- Synthesizable, parametrised successor to the per-design co-sim compare task.
- Aligns a golden output stream with a netlist (DUT) output stream through a configurable delay, then compares them under a bit mask.
- Counts matches and mismatches, captures the first mismatch, and produces a registered pass/fail verdict.
- Sits in co-sim benches between the golden instance and the post-synth/post-route instance, and is reusable for emulation builds.

Parameters:
- DATA_W, 128, width of compared outputs.
- ALIGN_DLY, 1, cycles the golden data and strobe are delayed to match DUT latency (0..15).
- SETTLE, 5, cycles after start before comparisons are enabled (1..255).
- CNT_W, 16, width of counters and cycle stamp.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- stop  in  1  end of stimulus; honoured only in SETTLE or RUN.
- sample_en  in  1  compare strobe, qualifies golden_data in the same cycle.
- golden_data  in  DATA_W  reference output.
- dut_data  in  DATA_W  netlist output.
- cmp_mask  in  DATA_W  1 = bit compared; sampled with golden_data.
- busy  out  1  high in SETTLE, RUN and DRAIN.
- done  out  1  high in DONE.
- pass  out  1  valid while done.
- fail  out  1  valid while done.
- mm_pulse  out  1  one-cycle pulse per mismatch.
- match_cnt  out  CNT_W  compares that matched.
- mismatch_cnt  out  CNT_W  compares that mismatched.
- first_mm_golden  out  DATA_W  aligned golden value at the first mismatch.
- first_mm_dut  out  DATA_W  dut value at the first mismatch.
- first_mm_cycle  out  CNT_W  cycle stamp of the first mismatch.

Behaviour:
- Reset: state=IDLE, align pipeline flushed (strobes 0), all outputs 0. rst overrides everything, including mid-run; outputs are 0 on the cycle after rst is sampled.
- FSM: IDLE -start-> SETTLE; SETTLE, after SETTLE cycles -> RUN; SETTLE or RUN -stop-> DRAIN; DRAIN, after ALIGN_DLY+1 cycles -> DONE; DONE -start-> SETTLE.
- start in SETTLE, RUN or DRAIN is ignored. stop in IDLE, DONE or DRAIN is ignored.
- start and stop together in IDLE/DONE: start wins.
- start from IDLE/DONE clears counters, first-mismatch capture, cycle stamp and the pipeline in the same edge.
- Alignment:
  - golden_data, cmp_mask and sample_en pass through an ALIGN_DLY-stage shift register. ALIGN_DLY=0 means direct.
  - The pipeline input strobe is forced to 0 in any state other than RUN, so strobes in SETTLE or DRAIN are never injected.
- Compare:
  - Occurs in a cycle where the aligned strobe is 1 and state is RUN or DRAIN.
  - mismatch = |((g_al ^ dut_data) & m_al).
  - Result is registered: counters and mm_pulse update 1 cycle after the compare. Total latency from golden sample to counter update is ALIGN_DLY+1.
- Counters: match_cnt and mismatch_cnt saturate at all-ones and never wrap.
- Cycle stamp: increments each cycle in RUN or DRAIN, starting at 0 on the first RUN cycle; saturates.
- First mismatch: first_mm_* loads only when mismatch_cnt==0 before the increment. It holds thereafter, including after mismatch_cnt saturates.
- Verdict on entry to DONE:
  - pass = (mismatch_cnt==0) && (match_cnt!=0).
  - fail = !pass, so zero compares is a failure.
  - pass/fail are held until rst or start; pass and fail are never both 1.
- DRAIN: its ALIGN_DLY+1 length guarantees every strobe accepted in RUN is compared and counted before done rises.

Test Plan:
- All-match run, ALIGN_DLY=1, SETTLE=5:
  - start, 5 cycles, then 100 strobes with dut = golden delayed 1 cycle, then stop.
  - Required: match_cnt=100, mismatch_cnt=0, pass=1, done exactly ALIGN_DLY+2 cycles after stop.
- Single corrupted sample:
  - Flip dut bit 127 on strobe 37 (value 0xFFFF..FF vs 0x7FFF..FF).
  - Required: one mm_pulse, mismatch_cnt=1, first_mm_cycle=36, first_mm_golden=0xFFFF..FF, first_mm_dut=0x7FFF..FF, fail=1.
- Mask:
  - cmp_mask=0x0000..FFFF with a difference only in bits [127:16].
  - Required: mismatch_cnt=0, pass=1.
- Boundaries:
  - Strobes during SETTLE: not counted.
  - stop during SETTLE: DONE with fail=1 (zero compares).
  - CNT_W=4 with 20 mismatches: mismatch_cnt=15, first_mm values unchanged after saturation.
- Reset mid-run:
  - rst after 50 strobes.
  - Required: next cycle all outputs 0, state IDLE; a fresh start yields clean counts.
- Restart from DONE:
  - start with stop high in the same cycle.
  - Required: counters clear, busy=1, FSM in SETTLE.
